// File: rtl/sam_mem_pkg.sv
// Shared types and sizing helpers for the sam_rv32i data-memory responder.
package sam_mem_pkg;

  // Default number of 32-bit words in the data memory.
  localparam int DM_WORDS = 32;

  // One response as it travels through the latency pipeline and the FIFO.
  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] data;
  } rsp_rec_t;

  // One latency-pipeline stage: a response record plus its occupancy bit.
  typedef struct packed {
    logic     valid;
    rsp_rec_t rec;
  } pipe_ent_t;

  // Width of a counter that must hold every value from 0 to fifo_depth.
  function automatic int cnt_w(input int fifo_depth);
    return $clog2(fifo_depth + 1);
  endfunction

endpackage

// File: rtl/sam_dmem_resp_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
//
// Handshake rules, identical on both channels:
//   - A transfer happens on a rising clk edge where valid and ready are both 1.
//   - The sender holds valid and its payload until that transfer completes.
//   - req_ready comes from registered credit state only, never from req_valid or rsp_ready.
//   - rsp_valid/rsp_we/rsp_err/rsp_rdata are held stable while rsp_valid=1 and rsp_ready=0.
interface sam_dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_we;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we
  );
endinterface

// File: rtl/sam_rsp_fifo.sv
// Synchronous response FIFO. The caller's credit scheme keeps it from
// overflowing, so a push is always taken; a pop on an empty FIFO is ignored.
// The head reads as all-zero while the FIFO is empty.
module sam_rsp_fifo
  import sam_mem_pkg::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type rec_t      = rsp_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic empty,
  output logic full
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = cnt_w(FIFO_DEPTH);

  rec_t          buf_q [FIFO_DEPTH];
  rec_t          buf_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop_ok = pop & ~empty;
  assign head   = empty ? rec_t'('0) : buf_q[rd_ptr_q];

  // Next-state: write at the tail on push, advance the head on pop.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      buf_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + CW'(push) - CW'(pop_ok);
  end

  // State registers; reset empties the FIFO and clears the storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sam_dmem_resp.sv
// Data-memory responder: performs the access when a request is accepted,
// carries the result through a fixed LATENCY pipeline into a response FIFO,
// and limits outstanding requests to FIFO_DEPTH with a credit counter.
module sam_dmem_resp
  import sam_mem_pkg::*;
#(
  parameter int DEPTH      = DM_WORDS,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             RN,
  sam_dmem_resp_if.slave                   bus,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     dbg_in_flight,
  output logic                             dbg_fifo_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(FIFO_DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  pipe_ent_t     pipe_q [LATENCY];
  pipe_ent_t     pipe_d [LATENCY];
  logic [CW-1:0] in_flight_q, in_flight_d;

  logic          accept;
  logic          pop;
  logic          in_range;
  logic [AW-1:0] idx;
  rsp_rec_t      stage0;
  rsp_rec_t      head;
  logic          fifo_empty;
  logic          fifo_full;

  assign in_range      = (bus.req_addr < 32'(DEPTH));
  assign idx           = bus.req_addr[AW-1:0];
  // Every pipeline and FIFO entry holds a credit, so capping in_flight at
  // FIFO_DEPTH is what makes the FIFO unable to overflow.
  assign bus.req_ready = (in_flight_q < CW'(FIFO_DEPTH));
  assign accept        = bus.req_valid & bus.req_ready;
  assign pop           = bus.rsp_valid & bus.rsp_ready;

  // Store path: out-of-range stores are dropped.
  always_comb begin
    mem_d = mem_q;
    if (accept && in_range && bus.req_we) mem_d[idx] = bus.req_wdata;
  end

  // Response record formed at acceptance; the read sees all earlier stores.
  always_comb begin
    stage0.we   = bus.req_we;
    stage0.err  = ~in_range;
    stage0.data = '0;
    if (in_range && !bus.req_we) stage0.data = mem_q[idx];
  end

  // Latency pipeline: stage 0 captures the request, later stages shift.
  always_comb begin
    pipe_d[0].valid = accept;
    pipe_d[0].rec   = accept ? stage0 : rsp_rec_t'('0);
    for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Credits: +1 on acceptance, -1 on response handshake.
  always_comb begin
    in_flight_d = in_flight_q + CW'(accept) - CW'(pop);
  end

  // State registers; reset clears memory, pipeline and credits.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++)   mem_q[i]  <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
      in_flight_q <= '0;
    end else begin
      mem_q       <= mem_d;
      pipe_q      <= pipe_d;
      in_flight_q <= in_flight_d;
    end
  end

  sam_rsp_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .rec_t      (rsp_rec_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (RN),
    .push      (pipe_q[LATENCY-1].valid),
    .push_data (pipe_q[LATENCY-1].rec),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_we    = head.we;
  assign bus.rsp_err   = head.err;
  assign bus.rsp_rdata = head.data;

  assign dbg_in_flight = in_flight_q;
  assign dbg_fifo_full = fifo_full;

endmodule
